// File: rtl/hqm_AW_pkg.sv
// Shared helpers for the hqm_AW block family.
package hqm_AW_pkg;

    // Index width for n items, never narrower than one bit.
    function automatic int max1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hqm_AW_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after a rotating
// pointer; the pointer moves past the winner only when update is asserted.
module hqm_AW_rr_arb
    import hqm_AW_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GW = max1_clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic               grant_v,
    output logic [GW-1:0]      grant
);

    logic [GW-1:0] ptr;

    // Pick the lowest requester at or above ptr, else wrap to the lowest requester overall.
    always_comb begin
        grant_v = 1'b0;
        grant   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_v && req[i] && (GW'(i) >= ptr)) begin
                grant_v = 1'b1;
                grant   = GW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_v && req[i]) begin
                grant_v = 1'b1;
                grant   = GW'(i);
            end
        end
    end

    // Advance the pointer to one past the winner, wrapping at NUM_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
        end
    end

endmodule

// File: rtl/hqm_aw_data_shadow_mc.sv
// Multi-channel data shadow: holds the latest value per channel, coalesces
// undelivered updates (counting each loss) and serialises deliveries onto a
// single valid/ready output stage via a round-robin arbiter.
module hqm_aw_data_shadow_mc
    import hqm_AW_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_CH      = 4,
    parameter logic [WIDTH-1:0] RST_DEFAULT = '0,
    parameter int               CNT_WIDTH   = 8,
    localparam int              CH_W        = max1_clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           in_v,
    input  logic [NUM_CH*WIDTH-1:0]     in_data,
    output logic [NUM_CH*WIDTH-1:0]     data_f,
    output logic [NUM_CH-1:0]           pend_f,
    output logic [NUM_CH*CNT_WIDTH-1:0] ovf_cnt_f,
    input  logic                        clr_ovf,
    output logic                        out_v,
    input  logic                        out_ready,
    output logic [CH_W-1:0]             out_ch,
    output logic [WIDTH-1:0]            out_data
);

    logic             stage_free;
    logic             load;
    logic             grant_v;
    logic [CH_W-1:0]  grant;
    logic [WIDTH-1:0] data_arr [NUM_CH];

    assign stage_free = !out_v || out_ready;
    assign load       = stage_free && grant_v;

    hqm_AW_rr_arb #(
        .NUM_REQ (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pend_f),
        .update  (load),
        .grant_v (grant_v),
        .grant   (grant)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0]     data_r;
        logic                 pend_r;
        logic [CNT_WIDTH-1:0] cnt_r;
        logic                 load_ch;
        logic                 ovf;

        assign load_ch = load && (grant == CH_W'(i));
        // A capture that coincides with this channel's load is a fresh update, not a loss.
        assign ovf     = in_v[i] && pend_r && !load_ch;

        // Capture the newest value and track whether it still awaits loading.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_r <= RST_DEFAULT;
                pend_r <= 1'b0;
            end else begin
                if (in_v[i]) begin
                    data_r <= in_data[i*WIDTH +: WIDTH];
                end
                pend_r <= in_v[i] || (pend_r && !load_ch);
            end
        end

        // Saturating loss counter; an overflow alongside clear leaves a count of one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= '0;
            end else if (clr_ovf) begin
                cnt_r <= ovf ? CNT_WIDTH'(1) : '0;
            end else if (ovf && (cnt_r != '1)) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end

        assign data_f[i*WIDTH +: WIDTH]         = data_r;
        assign pend_f[i]                        = pend_r;
        assign ovf_cnt_f[i*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
        assign data_arr[i]                      = data_r;
    end

    // Output stage: reload whenever free, hold channel and data under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v    <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
        end else if (stage_free) begin
            out_v <= grant_v;
            if (grant_v) begin
                out_ch   <= grant;
                out_data <= data_arr[grant];
            end
        end
    end

endmodule

// File: tb/tb_hqm_aw_data_shadow_mc.sv
// Self-checking bench for hqm_aw_data_shadow_mc: table-driven single updates,
// scoreboarded deliveries and hand-written multi-cycle corner cases.
module tb_hqm_aw_data_shadow_mc;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int S_CNT  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        in_v;
    logic [NUM_CH*WIDTH-1:0]  in_data;
    logic [NUM_CH*WIDTH-1:0]  data_f;
    logic [NUM_CH-1:0]        pend_f;
    logic [NUM_CH*CNT_W-1:0]  ovf_cnt_f;
    logic                     clr_ovf;
    logic                     out_v;
    logic                     out_ready;
    logic [1:0]               out_ch;
    logic [WIDTH-1:0]         out_data;

    logic [NUM_CH-1:0]        s_in_v;
    logic [NUM_CH*WIDTH-1:0]  s_in_data;
    logic [NUM_CH*WIDTH-1:0]  s_data_f;
    logic [NUM_CH-1:0]        s_pend_f;
    logic [NUM_CH*S_CNT-1:0]  s_ovf_cnt_f;
    logic                     s_clr_ovf;
    logic                     s_out_v;
    logic                     s_out_ready;
    logic [1:0]               s_out_ch;
    logic [WIDTH-1:0]         s_out_data;

    hqm_aw_data_shadow_mc #(
        .WIDTH       (WIDTH),
        .NUM_CH      (NUM_CH),
        .RST_DEFAULT (32'hA5),
        .CNT_WIDTH   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_v      (in_v),
        .in_data   (in_data),
        .data_f    (data_f),
        .pend_f    (pend_f),
        .ovf_cnt_f (ovf_cnt_f),
        .clr_ovf   (clr_ovf),
        .out_v     (out_v),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    hqm_aw_data_shadow_mc #(
        .WIDTH       (WIDTH),
        .NUM_CH      (NUM_CH),
        .RST_DEFAULT (32'h0),
        .CNT_WIDTH   (S_CNT)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_v      (s_in_v),
        .in_data   (s_in_data),
        .data_f    (s_data_f),
        .pend_f    (s_pend_f),
        .ovf_cnt_f (s_ovf_cnt_f),
        .clr_ovf   (s_clr_ovf),
        .out_v     (s_out_v),
        .out_ready (s_out_ready),
        .out_ch    (s_out_ch),
        .out_data  (s_out_data)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    exp_t sb [$];

    typedef struct {
        int unsigned ch;
        logic [31:0] data;
        logic [3:0]  exp_pend;
        logic [1:0]  exp_ch;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dsl(input int i);
        return data_f[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [7:0] csl(input int i);
        return ovf_cnt_f[i*CNT_W +: CNT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input logic [31:0] d);
        in_v = '0;
        in_v[ch] = 1'b1;
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = d;
        sb.push_back(e);
    endtask

    // Scoreboard: every accepted delivery of the main instance must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_v && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_delivery: got ch %0d data 0x%0h, expected none", out_ch, out_data);
            end else begin
                e = sb.pop_front();
                chk("deliver_ch", 64'(out_ch), 64'(e.ch));
                chk("deliver_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{2, 32'h0000_1234, 4'b0100, 2'd2, 32'h0000_1234};
        vt[1] = '{0, 32'hDEAD_BEEF, 4'b0001, 2'd0, 32'hDEAD_BEEF};
        vt[2] = '{3, 32'h0000_0000, 4'b1000, 2'd3, 32'h0000_0000};
        vt[3] = '{1, 32'hFFFF_FFFF, 4'b0010, 2'd1, 32'hFFFF_FFFF};

        in_v = '0; in_data = '0; clr_ovf = 1'b0; out_ready = 1'b1;
        s_in_v = '0; s_in_data = '0; s_clr_ovf = 1'b0; s_out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();

        // Reset state
        for (int i = 0; i < NUM_CH; i++) chk("rst_data_f", 64'(dsl(i)), 64'h0000_00A5);
        chk("rst_pend_f", 64'(pend_f), 64'h0);
        chk("rst_ovf_cnt", 64'(ovf_cnt_f), 64'h0);
        chk("rst_out_v", 64'(out_v), 64'h0);
        chk("rst_out_ch", 64'(out_ch), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        rst_n = 1'b1;
        tick();

        // Fairness: all four at once deliver 0,1,2,3 back to back
        for (int i = 0; i < NUM_CH; i++) begin
            push(i, 32'h100 + 32'(i));
            in_data[i*WIDTH +: WIDTH] = 32'h100 + 32'(i);
        end
        in_v = 4'hF;
        tick();
        in_v = '0;
        chk("fair_pend", 64'(pend_f), 64'hF);
        for (int k = 0; k < NUM_CH; k++) begin
            tick();
            chk("fair_out_v", 64'(out_v), 64'h1);
            chk("fair_out_ch", 64'(out_ch), 64'(k));
        end
        tick();
        chk("fair_idle", 64'(out_v), 64'h0);

        // Repulse 0 and 3: pointer wrapped to 0, so 0 then 3
        push(0, 32'h200);
        push(3, 32'h203);
        in_data[0 +: WIDTH] = 32'h200;
        in_data[3*WIDTH +: WIDTH] = 32'h203;
        in_v = 4'b1001;
        tick();
        in_v = '0;
        tick();
        chk("repulse_first", 64'(out_ch), 64'h0);
        tick();
        chk("repulse_second", 64'(out_ch), 64'h3);
        tick();

        // Table-driven single updates with the stage free
        for (int v = 0; v < 4; v++) begin
            push(int'(vt[v].ch), vt[v].data);
            pulse(int'(vt[v].ch), vt[v].data);
            tick();
            in_v = '0;
            chk("vec_data_f", 64'(dsl(int'(vt[v].ch))), 64'(vt[v].data));
            chk("vec_pend_set", 64'(pend_f), 64'(vt[v].exp_pend));
            chk("vec_out_v_lat1", 64'(out_v), 64'h0);
            tick();
            chk("vec_out_v", 64'(out_v), 64'h1);
            chk("vec_out_ch", 64'(out_ch), 64'(vt[v].exp_ch));
            chk("vec_out_data", 64'(out_data), 64'(vt[v].exp_out));
            chk("vec_pend_clr", 64'(pend_f), 64'h0);
            tick();
        end

        // Coalescing under backpressure: stage blocked by channel 3
        out_ready = 1'b0;
        push(3, 32'hCAFE_0003);
        pulse(3, 32'hCAFE_0003);
        tick();
        in_v = '0;
        tick();
        chk("bp_out_v", 64'(out_v), 64'h1);
        chk("bp_out_ch", 64'(out_ch), 64'h3);
        push(1, 32'd5);
        for (int v = 1; v <= 5; v++) begin
            pulse(1, 32'(v));
            tick();
        end
        in_v = '0;
        chk("coal_ovf_cnt", 64'(csl(1)), 64'd4);
        chk("coal_data_f", 64'(dsl(1)), 64'd5);
        chk("coal_pend", 64'(pend_f), 64'b0010);
        chk("hold_out_ch", 64'(out_ch), 64'h3);
        chk("hold_out_data", 64'(out_data), 64'hCAFE_0003);
        out_ready = 1'b1;
        tick();
        chk("coal_deliver_ch", 64'(out_ch), 64'h1);
        chk("coal_deliver_data", 64'(out_data), 64'd5);
        tick();
        chk("coal_single", 64'(out_v), 64'h0);

        // Load and capture in the same cycle on channel 0
        push(0, 32'hAAAA_0000);
        push(0, 32'hBBBB_0000);
        pulse(0, 32'hAAAA_0000);
        tick();
        pulse(0, 32'hBBBB_0000);
        tick();
        in_v = '0;
        chk("lc_out_data_old", 64'(out_data), 64'hAAAA_0000);
        chk("lc_pend_kept", 64'(pend_f[0]), 64'h1);
        chk("lc_data_f_new", 64'(dsl(0)), 64'hBBBB_0000);
        chk("lc_no_ovf", 64'(csl(0)), 64'h0);
        tick();
        chk("lc_out_data_new", 64'(out_data), 64'hBBBB_0000);
        chk("lc_pend_clr", 64'(pend_f), 64'h0);
        tick();

        // Counter clear on the main instance
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf_all", 64'(ovf_cnt_f), 64'h0);

        // Saturation (2-bit counter) and clear coinciding with an overflow
        s_in_v = 4'b0001;
        for (int v = 0; v < 8; v++) begin
            s_in_data[0 +: WIDTH] = 32'(v);
            tick();
        end
        chk("sat_cnt", 64'(s_ovf_cnt_f[1:0]), 64'd3);
        chk("sat_pend", 64'(s_pend_f[0]), 64'h1);
        s_clr_ovf = 1'b1;
        tick();
        chk("clr_with_ovf", 64'(s_ovf_cnt_f[1:0]), 64'd1);
        s_in_v = '0;
        tick();
        s_clr_ovf = 1'b0;
        chk("clr_no_ovf", 64'(s_ovf_cnt_f[1:0]), 64'd0);

        // Reset mid-operation discards pending updates and the output stage
        out_ready = 1'b0;
        pulse(2, 32'h7777_0002);
        tick();
        pulse(1, 32'h7777_0001);
        tick();
        in_v = '0;
        chk("sb_before_rst", 64'(sb.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_v", 64'(out_v), 64'h0);
        chk("mid_rst_pend", 64'(pend_f), 64'h0);
        chk("mid_rst_data_f2", 64'(dsl(2)), 64'h0000_00A5);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 64'(out_v), 64'h0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
